// File: rtl/sram_bank_array.sv
// sram_bank_array: banked byte-writable SRAM with a zeroing sweep after reset or on request
module sram_bank_array #(
    parameter int BW_DATA  = 64,
    parameter int BW_ADDR  = 6,
    parameter int NUM_BANK = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_init,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_we,
    input  logic [BW_ADDR-1:0]   i_req_addr,
    input  logic [BW_DATA-1:0]   i_req_wdata,
    input  logic [BW_DATA/8-1:0] i_req_be,
    output logic                 o_rsp_valid,
    output logic [BW_DATA-1:0]   o_rsp_data,
    output logic                 o_init_done
);
    localparam int BW_BANK = $clog2(NUM_BANK);
    localparam int DEPTH   = (2 ** BW_ADDR) / NUM_BANK;
    localparam int BW_BE   = BW_DATA / 8;
    localparam int BW_IDX  = BW_ADDR - BW_BANK;
    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;
    localparam logic [BW_IDX-1:0] LAST = BW_IDX'(DEPTH - 1);

    logic               state_q, state_d;
    logic [BW_IDX-1:0]  cnt_q, cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [BW_BANK-1:0] bank_q, bank_d;
    logic [BW_DATA-1:0] hold_q, hold_d;
    logic [BW_DATA-1:0] rd_data [NUM_BANK];
    logic [BW_BANK-1:0] req_bank;
    logic [BW_IDX-1:0]  req_idx;
    logic               rd_acc, wr_acc;

    assign req_bank    = i_req_addr[BW_ADDR-1 -: BW_BANK];
    assign req_idx     = i_req_addr[BW_IDX-1:0];
    assign o_req_ready = (state_q == ST_RUN) & ~i_init;
    assign rd_acc      = i_req_valid & o_req_ready & ~i_req_we;
    assign wr_acc      = i_req_valid & o_req_ready & i_req_we;
    assign o_rsp_valid = rsp_valid_q;
    assign o_init_done = (state_q == ST_RUN);
    // Outside a response the data port replays the last value it showed.
    assign o_rsp_data  = rsp_valid_q ? rd_data[bank_q] : hold_q;

    always_comb begin
        state_d     = (state_q == ST_INIT) ? ((cnt_q == LAST) ? ST_RUN : ST_INIT)
                                           : (i_init ? ST_INIT : ST_RUN);
        cnt_d       = (state_q == ST_INIT) ? cnt_q + 1'b1 : '0;
        rsp_valid_d = rd_acc;
        bank_d      = rd_acc ? req_bank : bank_q;
        hold_d      = o_rsp_data;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            bank_q      <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            bank_q      <= bank_d;
            hold_q      <= hold_d;
        end
    end

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        logic [BW_DATA-1:0] mem [DEPTH];
        logic [BW_DATA-1:0] rd_q;
        logic               sel;
        assign sel        = (req_bank == BW_BANK'(b));
        assign rd_data[b] = rd_q;
        always_ff @(posedge i_clk) begin
            if (state_q == ST_INIT) begin
                mem[cnt_q] <= '0;
            end else if (wr_acc && sel) begin
                for (int k = 0; k < BW_BE; k++) begin
                    if (i_req_be[k]) mem[req_idx][8*k +: 8] <= i_req_wdata[8*k +: 8];
                end
            end
            if (rd_acc && sel) rd_q <= mem[req_idx];
        end
    end
endmodule
